// File: rtl/apr_fm_parity.sv
// ----------------------------------------------------------------------------
// apr_fm_parity
//
// Fast-memory (AC block) parity store/check stage. Sits directly downstream of
// the EDP slice FM parity outputs.
//
// On an FM write, the parity of each written halfword is stored in a
// FM_WORDS x 2 shadow array, and the half is marked valid. The array is
// indexed by {block, AC address}. On a checked FM read, the halfword parities
// are registered for one cycle. On the following edge they are compared
// against the shadow array. The first failing address and half are latched
// for the APR, and a saturating counter tracks the total number of errors.
//
// Ports
//   clk_fm_h               in   FM/APR clock, all state on rising edge
//   mr_reset_l             in   async active-low reset
//   edp_fm_parity_h[5:0]   in   slice parities; [2:0] left half, [5:3] right half
//   apr_fm_block_h[2:0]    in   FM block select
//   apr_fm_adr_h[3:0]      in   AC address within the block
//   con_fm_write_00to17_l  in   left-half FM write, active low
//   con_fm_write_18to35_l  in   right-half FM write, active low
//   con_fm_par_chk_en_h    in   current cycle is an FM read to be checked
//   diag_fm_par_force_h    in   invert the parity stored this cycle (fault injection)
//   apr_fm_par_clr_h       in   clear error latch, capture registers and counter
//   apr_fm_par_err_h       out  sticky parity error
//   apr_fm_par_err_adr_h   out  {block, adr} of the first error since clear
//   apr_fm_par_err_half_h  out  [1]=left, [0]=right failed at the first error
//   apr_fm_par_err_cnt_h   out  errors since clear, saturating
// ----------------------------------------------------------------------------
module apr_fm_parity #(
    parameter int FM_WORDS     = 128,
    parameter int ERR_CNT_BITS = 4
) (
    input  logic                        clk_fm_h,
    input  logic                        mr_reset_l,
    input  logic [5:0]                  edp_fm_parity_h,
    input  logic [2:0]                  apr_fm_block_h,
    input  logic [3:0]                  apr_fm_adr_h,
    input  logic                        con_fm_write_00to17_l,
    input  logic                        con_fm_write_18to35_l,
    input  logic                        con_fm_par_chk_en_h,
    input  logic                        diag_fm_par_force_h,
    input  logic                        apr_fm_par_clr_h,
    output logic                        apr_fm_par_err_h,
    output logic [$clog2(FM_WORDS)-1:0] apr_fm_par_err_adr_h,
    output logic [1:0]                  apr_fm_par_err_half_h,
    output logic [ERR_CNT_BITS-1:0]     apr_fm_par_err_cnt_h
);

    localparam int ADR_BITS = $clog2(FM_WORDS);
    localparam logic [ERR_CNT_BITS-1:0] CNT_ONE = ERR_CNT_BITS'(1);
    localparam logic [ERR_CNT_BITS-1:0] CNT_MAX = '1;

    // ------------------------------------------------------------------
    // Address and halfword parity of the current cycle
    // ------------------------------------------------------------------
    logic [ADR_BITS-1:0] fm_adr;
    logic                par_left;
    logic                par_right;
    logic                wr_left;
    logic                wr_right;
    logic                chk_start;

    assign fm_adr    = {apr_fm_block_h, apr_fm_adr_h};
    assign par_left  = ^edp_fm_parity_h[2:0];
    assign par_right = ^edp_fm_parity_h[5:3];
    assign wr_left   = ~con_fm_write_00to17_l;
    assign wr_right  = ~con_fm_write_18to35_l;

    // A write in the read cycle means the data is not a clean FM read, so the
    // check is dropped for that cycle.
    assign chk_start = con_fm_par_chk_en_h & ~wr_left & ~wr_right;

    // ------------------------------------------------------------------
    // Shadow parity array. The parity bits do not need a reset; they only
    // matter once the matching valid bit has been set by a write.
    // ------------------------------------------------------------------
    logic [FM_WORDS-1:0] par_l_mem;
    logic [FM_WORDS-1:0] par_r_mem;
    logic [FM_WORDS-1:0] vld_l_mem;
    logic [FM_WORDS-1:0] vld_r_mem;

    always_ff @(posedge clk_fm_h) begin
        if (wr_left) begin
            par_l_mem[fm_adr] <= par_left ^ diag_fm_par_force_h;
        end
        if (wr_right) begin
            par_r_mem[fm_adr] <= par_right ^ diag_fm_par_force_h;
        end
    end

    always_ff @(posedge clk_fm_h or negedge mr_reset_l) begin
        if (!mr_reset_l) begin
            vld_l_mem <= '0;
            vld_r_mem <= '0;
        end else begin
            if (wr_left) begin
                vld_l_mem[fm_adr] <= 1'b1;
            end
            if (wr_right) begin
                vld_r_mem[fm_adr] <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Check stage 1: capture the read address and recomputed parity
    // ------------------------------------------------------------------
    logic                pipe_vld;
    logic [ADR_BITS-1:0] pipe_adr;
    logic                pipe_par_l;
    logic                pipe_par_r;

    always_ff @(posedge clk_fm_h or negedge mr_reset_l) begin
        if (!mr_reset_l) begin
            pipe_vld   <= 1'b0;
            pipe_adr   <= '0;
            pipe_par_l <= 1'b0;
            pipe_par_r <= 1'b0;
        end else begin
            pipe_vld <= chk_start;
            if (chk_start) begin
                pipe_adr   <= fm_adr;
                pipe_par_l <= par_left;
                pipe_par_r <= par_right;
            end
        end
    end

    // ------------------------------------------------------------------
    // Check stage 2: compare against the shadow array. The array is read
    // after the previous edge's write has landed, so a write to the same
    // word in the cycle after a read is not seen by that read's check.
    // ------------------------------------------------------------------
    logic [1:0] miss;

    always_comb begin
        miss = 2'b00;
        if (pipe_vld) begin
            miss[1] = vld_l_mem[pipe_adr] & (pipe_par_l != par_l_mem[pipe_adr]);
            miss[0] = vld_r_mem[pipe_adr] & (pipe_par_r != par_r_mem[pipe_adr]);
        end
    end

    // ------------------------------------------------------------------
    // Error latch, first-error capture and saturating counter.
    // When a clear and a new miss land on the same edge, the miss wins: the
    // latch is treated as freshly cleared, so the miss is captured and the
    // count restarts at one.
    // ------------------------------------------------------------------
    logic                    err_q;
    logic [ADR_BITS-1:0]     err_adr_q;
    logic [1:0]              err_half_q;
    logic [ERR_CNT_BITS-1:0] err_cnt_q;
    logic                    any_miss;

    assign any_miss = |miss;

    always_ff @(posedge clk_fm_h or negedge mr_reset_l) begin
        if (!mr_reset_l) begin
            err_q      <= 1'b0;
            err_adr_q  <= '0;
            err_half_q <= 2'b00;
            err_cnt_q  <= '0;
        end else if (apr_fm_par_clr_h) begin
            err_q      <= any_miss;
            err_adr_q  <= any_miss ? pipe_adr : '0;
            err_half_q <= miss;
            err_cnt_q  <= any_miss ? CNT_ONE : '0;
        end else if (any_miss) begin
            err_q <= 1'b1;
            if (!err_q) begin
                err_adr_q  <= pipe_adr;
                err_half_q <= miss;
            end
            if (err_cnt_q != CNT_MAX) begin
                err_cnt_q <= err_cnt_q + CNT_ONE;
            end
        end
    end

    assign apr_fm_par_err_h      = err_q;
    assign apr_fm_par_err_adr_h  = err_adr_q;
    assign apr_fm_par_err_half_h = err_half_q;
    assign apr_fm_par_err_cnt_h  = err_cnt_q;

endmodule

// File: tb/tb_apr_fm_parity.sv
// ----------------------------------------------------------------------------
// tb_apr_fm_parity
//
// Directed bench for apr_fm_parity. A behavioural model holds the stored
// parity per word/half and the pending read, and every negedge the DUT outputs
// are compared with it. Hand-computed literal checks after each scenario pin
// the model itself.
// ----------------------------------------------------------------------------
module tb_apr_fm_parity;

    logic       clk;
    logic       rst_n;
    logic [5:0] fm_par;
    logic [2:0] blk;
    logic [3:0] ac;
    logic       wl_l;
    logic       wr_l;
    logic       chk;
    logic       frc;
    logic       clr;
    logic       err;
    logic [6:0] err_adr;
    logic [1:0] err_half;
    logic [3:0] err_cnt;

    apr_fm_parity dut (
        .clk_fm_h              (clk),
        .mr_reset_l            (rst_n),
        .edp_fm_parity_h       (fm_par),
        .apr_fm_block_h        (blk),
        .apr_fm_adr_h          (ac),
        .con_fm_write_00to17_l (wl_l),
        .con_fm_write_18to35_l (wr_l),
        .con_fm_par_chk_en_h   (chk),
        .diag_fm_par_force_h   (frc),
        .apr_fm_par_clr_h      (clr),
        .apr_fm_par_err_h      (err),
        .apr_fm_par_err_adr_h  (err_adr),
        .apr_fm_par_err_half_h (err_half),
        .apr_fm_par_err_cnt_h  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_on      = 1'b0;

    function automatic void check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: index 1 = left half, 0 = right half.
    // ------------------------------------------------------------------
    bit [1:0] m_par [128];
    bit [1:0] m_vld [128];
    bit       m_pend   = 0;
    int       m_pend_a = 0;
    bit [1:0] m_pend_p = 0;
    bit       m_err    = 0;
    int       m_adr    = 0;
    bit [1:0] m_half   = 0;
    int       m_cnt    = 0;

    bit [1:0] mm_miss;
    bit [1:0] mm_p;
    bit [1:0] mm_wr;
    int       mm_a;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 128; i++) m_vld[i] = 2'b00;
            m_pend = 0;
            m_err  = 0;
            m_adr  = 0;
            m_half = 0;
            m_cnt  = 0;
        end else begin
            // Resolve the pending read against what is stored right now.
            mm_miss = 2'b00;
            if (m_pend) begin
                for (int h = 0; h < 2; h++) begin
                    if (m_vld[m_pend_a][h] && (m_par[m_pend_a][h] != m_pend_p[h]))
                        mm_miss[h] = 1'b1;
                end
            end
            if (clr) begin
                m_err = 0; m_adr = 0; m_half = 0; m_cnt = 0;
            end
            if (mm_miss != 2'b00) begin
                if (!m_err) begin
                    m_adr  = m_pend_a;
                    m_half = mm_miss;
                end
                m_err = 1;
                m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
            end
            // Current cycle: new read and writes.
            mm_a  = int'({blk, ac});
            mm_p  = {^fm_par[2:0], ^fm_par[5:3]};
            mm_wr = {~wl_l, ~wr_l};
            m_pend   = chk && (mm_wr == 2'b00);
            m_pend_a = mm_a;
            m_pend_p = mm_p;
            for (int h = 0; h < 2; h++) begin
                if (mm_wr[h]) begin
                    m_par[mm_a][h] = mm_p[h] ^ frc;
                    m_vld[mm_a][h] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("err",      int'(err),      int'(m_err));
            check("err_adr",  int'(err_adr),  m_adr);
            check("err_half", int'(err_half), int'(m_half));
            check("err_cnt",  int'(err_cnt),  m_cnt);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers. Inputs change 2 time units after the rising edge.
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_idle();
        fm_par = 6'b0; blk = 3'd0; ac = 4'd0;
        wl_l = 1'b1; wr_l = 1'b1; chk = 1'b0; frc = 1'b0; clr = 1'b0;
    endtask

    task automatic idle(input int n);
        set_idle();
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic fm_write(input int a, input bit [5:0] p, input bit left, input bit right,
                            input bit force_par);
        set_idle();
        blk = 3'(a >> 4); ac = 4'(a);
        fm_par = p; wl_l = ~left; wr_l = ~right; frc = force_par;
        step();
    endtask

    task automatic fm_read(input int a, input bit [5:0] p);
        set_idle();
        blk = 3'(a >> 4); ac = 4'(a);
        fm_par = p; chk = 1'b1;
        step();
    endtask

    task automatic par_clear();
        set_idle();
        clr = 1'b1;
        step();
    endtask

    task automatic expect_out(input string tag, input int e_err, input int e_adr,
                              input int e_half, input int e_cnt);
        check({tag, "_err"},  int'(err),      e_err);
        check({tag, "_adr"},  int'(err_adr),  e_adr);
        check({tag, "_half"}, int'(err_half), e_half);
        check({tag, "_cnt"},  int'(err_cnt),  e_cnt);
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        repeat (3) @(posedge clk);
        #2;
        rst_n  = 1'b1;
        cmp_on = 1'b1;
        expect_out("reset", 0, 0, 0, 0);

        // 1: matching read, no error.
        fm_write(7'h13, 6'b000001, 1, 1, 0);
        fm_read(7'h13, 6'b000001);
        idle(2);
        expect_out("t1", 0, 0, 0, 0);

        // 2: left-half mismatch, visible two edges after the read cycle.
        fm_write(7'h13, 6'b000001, 1, 1, 0);
        fm_read(7'h13, 6'b000011);
        check("t2_early_err", int'(err), 0);
        idle(1);
        expect_out("t2", 1, 8'h13, 2'b10, 1);

        // clear alone -> all zero
        par_clear();
        expect_out("clr", 0, 0, 0, 0);

        // 3: forced parity on 7F right half, then more misses, saturation.
        fm_write(7'h7F, 6'b000000, 0, 1, 1);
        fm_read(7'h7F, 6'b000000);
        idle(1);
        expect_out("t3a", 1, 8'h7F, 2'b01, 1);
        fm_write(7'h00, 6'b000000, 1, 1, 0);
        fm_read(7'h00, 6'b001000);
        idle(1);
        expect_out("t3b", 1, 8'h7F, 2'b01, 2);
        for (int i = 0; i < 16; i++) fm_read(7'h00, 6'b001000);
        idle(2);
        expect_out("t3c", 1, 8'h7F, 2'b01, 15);

        // 4: never-written word, and write with check in the same cycle.
        par_clear();
        fm_read(7'h05, 6'b111111);
        fm_read(7'h05, 6'b010110);
        idle(2);
        expect_out("t4a", 0, 0, 0, 0);
        set_idle();
        blk = 3'd1; ac = 4'd3; fm_par = 6'b000011; wl_l = 1'b0; chk = 1'b1;
        step();
        idle(2);
        expect_out("t4b", 0, 0, 0, 0);

        // 5: clear and a new miss on the same edge.
        fm_read(7'h00, 6'b001000);
        fm_read(7'h13, 6'b000001);
        expect_out("t5a", 1, 8'h00, 2'b01, 1);
        par_clear();
        expect_out("t5b", 1, 8'h13, 2'b10, 1);
        par_clear();
        expect_out("t5c", 0, 0, 0, 0);

        // 6: reset between read edge and check edge.
        fm_read(7'h13, 6'b000001);
        idle(1);
        check("t6_pre_err", int'(err), 1);
        fm_read(7'h13, 6'b000001);
        set_idle();
        rst_n = 1'b0;
        #1;
        expect_out("t6_rst", 0, 0, 0, 0);
        rst_n = 1'b1;
        idle(2);
        expect_out("t6_post", 0, 0, 0, 0);
        fm_read(7'h13, 6'b000001);
        idle(2);
        expect_out("t6_unvld", 0, 0, 0, 0);

        // Scattered words; model checks every cycle.
        for (int i = 0; i < 8; i++) begin
            int a;
            bit [5:0] p;
            bit [5:0] q;
            a = (i * 37 + 3) % 128;
            p = 6'(i * 11 + 5);
            q = p ^ 6'(1 << (i % 6));
            fm_write(a, p, (i % 3) != 1, (i % 3) != 2, 0);
            fm_read(a, p);
            fm_read(a, q);
        end
        idle(2);
        par_clear();

        // A write in the cycle after a read is not seen by that read.
        fm_write(7'h22, 6'b000000, 1, 1, 0);
        fm_read(7'h22, 6'b000000);
        fm_write(7'h22, 6'b001001, 1, 1, 0);
        idle(2);
        expect_out("wf", 0, 0, 0, 0);
        fm_read(7'h22, 6'b000000);
        idle(2);
        expect_out("wf2", 1, 8'h22, 2'b11, 1);

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
